// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic signal controller: phase encoding,
// default phase durations and the road-index width helper.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_ALLRED = 3'd0,
        PH_GREEN  = 3'd1,
        PH_YELLOW = 3'd2,
        PH_FLASH  = 3'd3
    } phase_t;

    localparam int DEF_NUM_ROADS    = 4;
    localparam int DEF_GREEN_TICKS  = 8;
    localparam int DEF_YELLOW_TICKS = 3;
    localparam int DEF_ALLRED_TICKS = 1;
    localparam int DEF_CNT_W        = 8;

    function automatic int road_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_next_road.sv
// Circular priority search: first road after cur (cur+1 .. cur-1) with demand.
// The demand of cur itself is never considered.
module rr_next_road #(
    parameter int NUM_ROADS = 4,
    parameter int RW        = 2
) (
    input  logic [RW-1:0]        cur,
    input  logic [NUM_ROADS-1:0] demand,
    output logic [RW-1:0]        nxt,
    output logic                 found
);

    int best;

    // Rank candidates by circular distance from cur; the nearest wins.
    always_comb begin
        best  = NUM_ROADS;
        nxt   = cur;
        found = 1'b0;
        for (int r = 0; r < NUM_ROADS; r++) begin
            if (demand[r] && (r != int'(cur)) &&
                (((r + NUM_ROADS - int'(cur)) % NUM_ROADS) < best)) begin
                best  = (r + NUM_ROADS - int'(cur)) % NUM_ROADS;
                nxt   = RW'(r);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_seq.sv
// Round-robin traffic signal sequencer with demand skipping and night flash mode.
// States: ALLRED | all red clearance ; GREEN | cur_road green ; YELLOW | cur_road yellow ; FLASH | all yellow blinking
module traffic_ctrl_seq
    import traffic_pkg::*;
#(
    parameter int NUM_ROADS    = DEF_NUM_ROADS,
    parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
    parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
    parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
    parameter int CNT_W        = DEF_CNT_W,
    localparam int RW          = road_w(NUM_ROADS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i,
    input  logic                 tick,
    input  logic [NUM_ROADS-1:0] demand,
    input  logic                 night,
    output logic [NUM_ROADS-1:0] red,
    output logic [NUM_ROADS-1:0] yellow,
    output logic [NUM_ROADS-1:0] green,
    output logic [RW-1:0]        cur_road,
    output logic [2:0]           phase
);

    phase_t               state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [RW-1:0]        road_n, nxt_q, nxt_n, srch;
    logic                 nv_q, nv_n, tog_q, tog_n, found;
    logic                 adv;
    logic [NUM_ROADS-1:0] red_n, yel_n, grn_n;

    assign adv   = i & tick;
    assign phase = state_q;

    rr_next_road #(.NUM_ROADS(NUM_ROADS), .RW(RW)) u_search (
        .cur   (cur_road),
        .demand(demand),
        .nxt   (srch),
        .found (found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PH_ALLRED;
            cnt_q    <= CNT_W'(ALLRED_TICKS - 1);
            cur_road <= RW'(NUM_ROADS - 1);
            nxt_q    <= '0;
            nv_q     <= 1'b0;
            tog_q    <= 1'b0;
            red      <= '1;
            yellow   <= '0;
            green    <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            cur_road <= road_n;
            nxt_q    <= nxt_n;
            nv_q     <= nv_n;
            tog_q    <= tog_n;
            red      <= red_n;
            yellow   <= yel_n;
            green    <= grn_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        road_n  = cur_road;
        nxt_n   = nxt_q;
        nv_n    = nv_q;
        tog_n   = tog_q;
        if (adv) begin
            case (state_q)
                PH_GREEN: begin
                    if (night) begin
                        state_n = PH_YELLOW;
                        cnt_n   = CNT_W'(YELLOW_TICKS - 1);
                        nv_n    = 1'b0;
                    end else if (cnt_q == '0) begin
                        if (found) begin
                            state_n = PH_YELLOW;
                            cnt_n   = CNT_W'(YELLOW_TICKS - 1);
                            nxt_n   = srch;
                            nv_n    = 1'b1;
                        end else begin
                            cnt_n = CNT_W'(GREEN_TICKS - 1);
                        end
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (cnt_q == '0) begin
                        state_n = PH_ALLRED;
                        cnt_n   = CNT_W'(ALLRED_TICKS - 1);
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
                PH_ALLRED: begin
                    if (cnt_q != '0) begin
                        cnt_n = cnt_q - 1'b1;
                    end else if (night) begin
                        state_n = PH_FLASH;
                        tog_n   = 1'b1;
                    end else begin
                        state_n = PH_GREEN;
                        cnt_n   = CNT_W'(GREEN_TICKS - 1);
                        nv_n    = 1'b0;
                        // Without a latched target (reset, flash, night abort) search live.
                        if (nv_q)
                            road_n = nxt_q;
                        else if (found)
                            road_n = srch;
                        else if (demand[cur_road])
                            road_n = cur_road;
                        else
                            road_n = (cur_road == RW'(NUM_ROADS - 1)) ? '0 : cur_road + RW'(1);
                    end
                end
                PH_FLASH: begin
                    if (!night) begin
                        state_n = PH_ALLRED;
                        cnt_n   = CNT_W'(ALLRED_TICKS - 1);
                        tog_n   = 1'b0;
                        nv_n    = 1'b0;
                    end else begin
                        tog_n = ~tog_q;
                    end
                end
                default: begin
                    state_n = PH_ALLRED;
                    cnt_n   = CNT_W'(ALLRED_TICKS - 1);
                end
            endcase
        end
    end

    always_comb begin
        red_n = '1;
        yel_n = '0;
        grn_n = '0;
        case (state_n)
            PH_GREEN: begin
                red_n[road_n] = 1'b0;
                grn_n[road_n] = 1'b1;
            end
            PH_YELLOW: begin
                red_n[road_n] = 1'b0;
                yel_n[road_n] = 1'b1;
            end
            PH_FLASH: begin
                red_n = '0;
                yel_n = {NUM_ROADS{tog_n}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_seq.sv
// Self-checking bench for traffic_ctrl_seq: a ticks-remaining behavioural model
// compared every cycle, plus literal expectations along a directed timeline.
module tb_traffic_ctrl_seq;

    localparam int N  = 4;
    localparam int G  = 3;
    localparam int Y  = 2;
    localparam int A  = 1;
    localparam int RW = 2;

    logic          clk = 0;
    logic          rst = 1;
    logic          i = 1, tick = 1, night = 0;
    logic [N-1:0]  demand = 4'b1111;
    logic [N-1:0]  red, yellow, green;
    logic [RW-1:0] cur_road;
    logic [2:0]    phase;

    int errors = 0;
    int checks = 0;
    int k = 0;

    traffic_ctrl_seq #(
        .NUM_ROADS(N), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .i(i), .tick(tick), .demand(demand), .night(night),
        .red(red), .yellow(yellow), .green(green), .cur_road(cur_road), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h want=%0h", name, k, got, exp);
        end
    endtask

    // Model: phase id 0 allred, 1 green, 2 yellow, 3 flash; m_left = ticks left in phase.
    int m_ph, m_road, m_left, m_tog, m_pend, s;

    function automatic int search(input int c, input logic [N-1:0] d);
        for (int j = 1; j < N; j++)
            if (d[(c + j) % N]) return (c + j) % N;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_road = N - 1; m_left = A; m_tog = 0; m_pend = -1;
        end else if (i && tick) begin
            case (m_ph)
                1: if (night) begin
                       m_ph = 2; m_left = Y; m_pend = -1;
                   end else if (m_left == 1) begin
                       s = search(m_road, demand);
                       if (s >= 0) begin m_pend = s; m_ph = 2; m_left = Y; end
                       else m_left = G;
                   end else m_left--;
                2: if (m_left == 1) begin m_ph = 0; m_left = A; end else m_left--;
                0: if (m_left > 1) m_left--;
                   else if (night) begin m_ph = 3; m_tog = 1; end
                   else begin
                       if (m_pend < 0) begin
                           s = search(m_road, demand);
                           m_pend = (s >= 0) ? s : (demand[m_road] ? m_road : (m_road + 1) % N);
                       end
                       m_road = m_pend; m_pend = -1; m_ph = 1; m_left = G;
                   end
                default: if (!night) begin m_ph = 0; m_left = A; m_tog = 0; m_pend = -1; end
                         else m_tog = 1 - m_tog;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] er, ey, eg;
        int lit;
        er = '1; ey = '0; eg = '0;
        if (m_ph == 1) begin er[m_road] = 0; eg[m_road] = 1; end
        if (m_ph == 2) begin er[m_road] = 0; ey[m_road] = 1; end
        if (m_ph == 3) begin er = '0; ey = m_tog ? '1 : '0; end
        chk("model_red", red, er);
        chk("model_yellow", yellow, ey);
        chk("model_green", green, eg);
        chk("model_phase", phase, m_ph);
        chk("model_cur_road", cur_road, m_road);
        if (phase != 3'd3) begin
            lit = 0;
            for (int r = 0; r < N; r++) if (!red[r]) lit++;
            chk("inv_one_lamp", ((red ^ yellow ^ green) == '1) && ((red & yellow) == 0)
                && ((red & green) == 0) && ((yellow & green) == 0), 1);
            chk("inv_single_road", lit <= 1, 1);
        end
    end

    task automatic run_to(input int target);
        while (k < target) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        chk("rst_red", red, 4'b1111);
        chk("rst_yellow", yellow, 4'b0000);
        chk("rst_green", green, 4'b0000);
        chk("rst_phase", phase, 0);
        chk("rst_cur_road", cur_road, 3);
        rst = 0;
        k = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        release_reset();
        run_to(1);  chk("k1_green0", green, 4'b0001);
        run_to(4);  chk("k4_yellow0", yellow, 4'b0001);
        run_to(6);  chk("k6_allred", phase, 0);
        run_to(7);  chk("k7_green1", green, 4'b0010); chk("k7_road", cur_road, 1);
        run_to(19); chk("k19_road3", cur_road, 3);
        run_to(25); chk("k25_wrap_road0", cur_road, 0);
        demand = 4'b0100;
        run_to(28); chk("k28_yellow0", yellow, 4'b0001);
        run_to(30); chk("k30_allred", phase, 0);
        run_to(31); chk("k31_green2", green, 4'b0100); chk("k31_road", cur_road, 2);
        demand = 4'b0001;
        run_to(37); chk("k37_green0", green, 4'b0001);
        run_to(46); chk("k46_hold_green0", green, 4'b0001); chk("k46_no_yellow", yellow, 0);
        demand = 4'b1111;
        run_to(49); chk("k49_yellow0", yellow, 4'b0001);
        run_to(52); chk("k52_green1", green, 4'b0010);
        night = 1;
        run_to(53); chk("k53_night_yellow1", yellow, 4'b0010);
        run_to(55); chk("k55_allred", phase, 0);
        run_to(56); chk("k56_flash_on", yellow, 4'b1111); chk("k56_phase", phase, 3);
        run_to(57); chk("k57_flash_off", yellow, 4'b0000);
        run_to(58); chk("k58_flash_on", yellow, 4'b1111);
        night = 0;
        run_to(59); chk("k59_allred", phase, 0);
        run_to(60); chk("k60_green2", green, 4'b0100);
        run_to(63); chk("k63_yellow2", yellow, 4'b0100);
        i = 0;
        run_to(73); chk("k73_frozen", yellow, 4'b0100); chk("k73_phase", phase, 2);
        i = 1;
        run_to(74); chk("k74_yellow_tail", yellow, 4'b0100);
        run_to(75); chk("k75_allred", phase, 0);
        run_to(76); chk("k76_green3", green, 4'b1000);
        tick = 0;
        run_to(79); chk("k79_tick_hold", green, 4'b1000);
        tick = 1;
        run_to(80);
        #2 rst = 1;
        #1;
        chk("async_red", red, 4'b1111);
        chk("async_green", green, 4'b0000);
        chk("async_yellow", yellow, 4'b0000);
        release_reset();
        run_to(1);  chk("r1_green0", green, 4'b0001);
        run_to(7);  chk("r7_road1", cur_road, 1);
        run_to(24); chk("r24_allred", phase, 0); chk("r24_road3", cur_road, 3);
        run_to(25); chk("r25_green0", green, 4'b0001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
